// File: rtl/reg_ctrl_pkg.sv
// Shared constants for the register-move sequencer: opcodes, FSM states and
// the bus-select offsets of the non-bank bus drivers.
package reg_ctrl_pkg;

  localparam logic [1:0] OP_MV  = 2'b00;  // Rd <= Rs
  localparam logic [1:0] OP_LDI = 2'b01;  // Rd <= imm
  localparam logic [1:0] OP_SWP = 2'b10;  // Rs <-> Rd through G
  localparam logic [1:0] OP_RSV = 2'b11;  // reserved, rejected

  // Bus drivers beyond the bank sit at NREG + offset.
  localparam int SEL_IMM = 0;
  localparam int SEL_TMP = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SW1,
    ST_SW2,
    ST_SW3,
    ST_ERR
  } state_e;

endpackage

// File: rtl/reg_onehot_dec.sv
// Index to one-hot decoder with enable; drives the bank load strobes so that
// at most one bank register is ever loaded per cycle.
module reg_onehot_dec #(
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]   idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    assign onehot[gi] = en && (idx == AW'(gi));
  end

endmodule

// File: rtl/reg_move_ctrl.sv
// Sequencer for register-to-register transfers over a shared datapath bus.
// Commands: MV (1 execute cycle), LDI (1 execute cycle), SWP (3 execute
// cycles through temp register G). Outputs decode only from the state and the
// fields latched at accept, never from the live cmd_* inputs.
// Optional build macro REG_MOVE_CTRL_STATS_EN adds cmd_count, a saturating
// count of done pulses.
module reg_move_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG),
  localparam int SW   = $clog2(NREG + 2)
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_src,
  input  logic [AW-1:0]   cmd_dst,
  input  logic [N-1:0]    cmd_imm,
  output logic [SW-1:0]   bus_sel,
  output logic [N-1:0]    imm_out,
  output logic [NREG-1:0] reg_load,
  output logic            tmp_load,
  output logic            done,
  output logic            err
`ifdef REG_MOVE_CTRL_STATS_EN
  ,
  output logic [15:0]     cmd_count
`endif
);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [N-1:0]  imm_q, imm_d;

  logic          src_ok, dst_ok;
  logic [AW-1:0] load_idx;
  logic          load_en;

  // Indices only go out of range when NREG is not a power of two; otherwise
  // every encodable index is a real register.
  if (NREG == (1 << AW)) begin : g_pow2
    assign src_ok = 1'b1;
    assign dst_ok = 1'b1;
  end else begin : g_npow2
    assign src_ok = ({1'b0, cmd_src} < (AW + 1)'(NREG));
    assign dst_ok = ({1'b0, cmd_dst} < (AW + 1)'(NREG));
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign imm_out   = imm_q;

  // State and latched command fields; clear abandons any command in flight.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MV;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
    end
  end

  // Next state: accept in IDLE, classify the command, then walk its sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          imm_d = cmd_imm;
          case (cmd_op)
            OP_MV:   state_d = (src_ok && dst_ok) ? ST_EXEC : ST_ERR;
            OP_LDI:  state_d = dst_ok ? ST_EXEC : ST_ERR;
            // A self-swap collapses to a single no-load done cycle in EXEC.
            OP_SWP:  state_d = !(src_ok && dst_ok) ? ST_ERR :
                               (cmd_src == cmd_dst) ? ST_EXEC : ST_SW1;
            OP_RSV:  state_d = ST_ERR;
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_SW1:  state_d = ST_SW2;
      ST_SW2:  state_d = ST_SW3;
      ST_SW3:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from state plus latched fields.
  always_comb begin
    bus_sel  = '0;
    load_idx = dst_q;
    load_en  = 1'b0;
    tmp_load = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_EXEC: begin
        done = 1'b1;
        if (op_q == OP_MV) begin
          bus_sel = SW'(src_q);
          load_en = 1'b1;
        end else if (op_q == OP_LDI) begin
          bus_sel = SW'(NREG + SEL_IMM);
          load_en = 1'b1;
        end
      end
      ST_SW1: begin
        bus_sel  = SW'(src_q);
        tmp_load = 1'b1;
      end
      ST_SW2: begin
        bus_sel  = SW'(dst_q);
        load_idx = src_q;
        load_en  = 1'b1;
      end
      ST_SW3: begin
        bus_sel = SW'(NREG + SEL_TMP);
        load_en = 1'b1;
        done    = 1'b1;
      end
      ST_ERR: err = 1'b1;
      default: ;
    endcase
  end

  reg_onehot_dec #(
    .NREG (NREG),
    .AW   (AW)
  ) u_load_dec (
    .idx    (load_idx),
    .en     (load_en),
    .onehot (reg_load)
  );

`ifdef REG_MOVE_CTRL_STATS_EN
  logic [15:0] count_q;

  // Saturating count of completed commands.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else if (done && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign cmd_count = count_q;
`endif

endmodule
